// File: rtl/cff_ser_pkg.sv
// Shared FSM encoding and default width for the cff_serializer block.
package cff_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } cff_state_e;

  localparam int CFF_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/cff_ser_bit.sv
// One shift-register stage: D flip-flop with async active-low clear and a load/shift mux.
module cff_ser_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  input  logic load_bit,
  input  logic shift_bit,
  output logic q
);

  // Stage storage; a parallel load takes priority over a shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_bit;
    end else if (shift) begin
      q <= shift_bit;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/cff_serializer.sv
// Parallel-to-serial framer, MSB first, with an optional even-parity trailer bit
// compiled in by defining CFF_SERIALIZER_PARITY_EN.
module cff_serializer
  import cff_ser_pkg::*;
#(
  parameter int WIDTH = CFF_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sframe,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  cff_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] shift_reg;
  logic             load_ready_r, ready_s;
  logic             sframe_r, sframe_s;
  logic             done_r, done_s;
  logic             accept_s, shifting_s, last_s;

  assign accept_s   = load_valid & load_ready_r;
  assign shifting_s = (state_r == SHIFT);
  assign last_s     = shifting_s && (cnt_r == CNT_LAST);

  // The top stage doubles as the serial output flop; zero fill leaves it low once idle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shift_in;
    if (i == 0) begin : g_lsb
      assign shift_in = 1'b0;
    end else begin : g_upper
      assign shift_in = shift_reg[i-1];
    end
    cff_ser_bit u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_s),
      .shift     (shifting_s),
      .load_bit  (load_data[i]),
      .shift_bit (shift_in),
      .q         (shift_reg[i])
    );
  end

`ifdef CFF_SERIALIZER_PARITY_EN
  logic par_r;
  logic par_bit_r;

  // Parity accumulates over bits as they leave; the full result is parked for the PAR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r     <= 1'b0;
      par_bit_r <= 1'b0;
    end else begin
      if (accept_s) begin
        par_r <= 1'b0;
      end else if (shifting_s) begin
        par_r <= par_r ^ shift_reg[WIDTH-1];
      end else begin
        par_r <= par_r;
      end
      par_bit_r <= last_s ? (par_r ^ shift_reg[WIDTH-1]) : 1'b0;
    end
  end

  assign sdata = shift_reg[WIDTH-1] | par_bit_r;
`else
  assign sdata = shift_reg[WIDTH-1];
`endif

  // Next state plus the next values of the registered handshake/framing outputs.
  always_comb begin
    state_s  = state_r;
    ready_s  = load_ready_r;
    sframe_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s  = SHIFT;
          ready_s  = 1'b0;
          sframe_s = 1'b1;
        end else begin
          ready_s  = 1'b1;
        end
      end
      SHIFT: begin
        if (last_s) begin
`ifdef CFF_SERIALIZER_PARITY_EN
          state_s  = PAR;
          ready_s  = 1'b0;
          sframe_s = 1'b1;
`else
          state_s  = IDLE;
          ready_s  = 1'b1;
          done_s   = 1'b1;
`endif
        end else begin
          ready_s  = 1'b0;
          sframe_s = 1'b1;
        end
      end
`ifdef CFF_SERIALIZER_PARITY_EN
      PAR: begin
        state_s = IDLE;
        ready_s = 1'b1;
        done_s  = 1'b1;
      end
`endif
      default: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      load_ready_r <= 1'b1;
      sframe_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      load_ready_r <= ready_s;
      sframe_r     <= sframe_s;
      done_r       <= done_s;
      if (accept_s) begin
        cnt_r <= '0;
      end else if (shifting_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign load_ready = load_ready_r;
  assign sframe     = sframe_r;
  assign done       = done_r;

endmodule

// File: tb/tb_cff_serializer.sv
// Scoreboard bench for cff_serializer (WIDTH=8 main instance, WIDTH=2 boundary instance).
module tb_cff_serializer;

  localparam int W = 8;
`ifdef CFF_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, sdata, sframe, done;
  logic [1:0] load_data2 = 2'b00;
  logic       load_valid2 = 1'b0;
  logic       load_ready2, sdata2, sframe2, done2;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic exp2_q[$];

  always #5 clk = ~clk;

  cff_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .sdata(sdata), .sframe(sframe), .done(done)
  );

  cff_serializer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_data(load_data2), .load_valid(load_valid2),
    .load_ready(load_ready2), .sdata(sdata2), .sframe(sframe2), .done(done2)
  );

  task automatic push8(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    if (PB == 1) exp_q.push_back(^d);
  endtask

  task automatic accept8(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait load_ready got %b expected 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    push8(d);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 8'($urandom);
  endtask

  task automatic collect8(input string name);
    logic e;
    for (int i = 0; i < W + PB; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 1'bx;
      checks++;
      if (sframe !== 1'b1 || sdata !== e || load_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s bit%0d sframe/sdata/ready got %b%b%b expected 1%b0",
                 name, i, sframe, sdata, load_ready, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sframe !== 1'b0 || sdata !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done done/sframe/sdata/ready got %b%b%b%b expected 1001",
               name, done, sframe, sdata, load_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1 || sframe !== 1'b0 || sdata !== 1'b0 || done !== 1'b0 ||
          load_ready2 !== 1'b1 || sframe2 !== 1'b0 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL reset ready/sframe/sdata/done got %b%b%b%b expected 1000",
                 load_ready, sframe, sdata, done);
      end
    end
    load_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1 || sframe !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready/sframe/done got %b%b%b expected 100",
               load_ready, sframe, done);
    end
  endtask

  task automatic test_basic();
    accept8(8'hA5);
    collect8("basic_a5");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || sframe !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done/sframe got %b%b expected 00", done, sframe);
    end
  endtask

  task automatic test_parity();
    accept8(8'h07);
    collect8("frame_07");
    accept8(8'h03);
    collect8("frame_03");
  endtask

  task automatic test_busy();
    accept8(8'h5A);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    push8(8'hFF);
    collect8("busy_first");
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    collect8("busy_second");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_tail done/ready got %b%b expected 01", done, load_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic e;
    accept8(8'hC3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (sframe !== 1'b1 || sdata !== e) begin
        errors++;
        $display("FAIL midrst_bit%0d sframe/sdata got %b%b expected 1%b", i, sframe, sdata, e);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || sframe !== 1'b0 || sdata !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_immediate ready/sframe/sdata/done got %b%b%b%b expected 1000",
               load_ready, sframe, sdata, done);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sframe !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold done/sframe got %b%b expected 00", done, sframe);
      end
    end
    rst_n = 1'b1;
    accept8(8'h3C);
    collect8("after_reset_3c");
  endtask

  task automatic test_width2();
    int   n;
    logic e;
    n = 0;
    @(negedge clk);
    while (load_ready2 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    load_valid2 = 1'b1;
    load_data2  = 2'b10;
    exp2_q.push_back(1'b1);
    exp2_q.push_back(1'b0);
    if (PB == 1) exp2_q.push_back(1'b1);
    @(posedge clk);
    #1;
    load_valid2 = 1'b0;
    load_data2  = 2'b01;
    for (int i = 0; i < 2 + PB; i++) begin
      @(negedge clk);
      if (exp2_q.size() > 0) e = exp2_q.pop_front();
      else e = 1'bx;
      checks++;
      if (sframe2 !== 1'b1 || sdata2 !== e || done2 !== 1'b0) begin
        errors++;
        $display("FAIL w2_bit%0d sframe/sdata/done got %b%b%b expected 1%b0",
                 i, sframe2, sdata2, done2, e);
      end
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || sframe2 !== 1'b0 || load_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL w2_done done/sframe/ready got %b%b%b expected 101", done2, sframe2, load_ready2);
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_done_pulse done got %b expected 0", done2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_busy();
    test_mid_reset();
    test_width2();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
